ram_sp_ctrl: RTL and testbench
==============================

# ram_sp_ctrl

Parametrised single-port synchronous RAM with a valid/ready request interface, per-byte write enables and a hardware clear engine. After reset, or on a clear request, it zero-fills every word before it accepts traffic. It is the general-purpose data/instruction memory for the softcore CPU and replaces the fixed 256×8 RAM. Storage is a plain synchronous array so the synthesis tool infers block RAM.

## Interface
- `DATA_W`, 8: word width in bits; must be a multiple of 8.
- `ADDR_W`, 8: address width. Depth is `DEPTH = 2**ADDR_W` words.
- `INIT_VAL`, 0: `DATA_W`-bit value the clear engine writes to every word.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `clr`  in  1  level; a request to re-run the clear engine.
- `req_valid`  in  1  the requester presents an operation.
- `req_ready`  out  1  the block can accept an operation this cycle.
- `req_we`  in  1  0 means read, 1 means write.
- `req_addr`  in  `ADDR_W`  word address.
- `req_wdata`  in  `DATA_W`  write data.
- `req_be`  in  `DATA_W/8`  byte enables. Bit i covers `wdata[8i+7:8i]`.
- `rsp_valid`  out  1  one-cycle pulse: `rsp_rdata` holds read data.
- `rsp_rdata`  out  `DATA_W`  read data. It holds its last value when `rsp_valid` is low.
- `init_done`  out  1  high once the clear engine has completed.

## Operation
- The FSM has two states: `INIT` (clear engine) and `RUN`.
- **Reset:**
  - Async assert of `rst_n` forces `INIT`.
  - It also sets clear counter `cnt=0`, `req_ready=0`, `rsp_valid=0`, `rsp_rdata=0`, `init_done=0`.
  - Memory contents are not reset.
- **INIT:**
  - Each cycle writes `INIT_VAL` to `mem[cnt]` and increments `cnt`.
  - When the write to `cnt==DEPTH-1` completes, `cnt` wraps to 0, the state goes to `RUN` and `init_done` rises.
  - The whole pass takes exactly `DEPTH` cycles.
  - `req_*` inputs are ignored during `INIT`.
- **RUN:**
  - `req_ready = (state==RUN) && !clr`. This is combinational from the state register and `clr`.
  - An operation is accepted when `req_valid && req_ready`.
  - Accepted write: for each byte i with `req_be[i]=1`, set `mem[req_addr]` byte i = `req_wdata` byte i. Other bytes are unchanged. Writes produce no response.
  - A write with `req_be=0` is accepted and is a no-op.
  - Accepted read: the word at `req_addr` appears on `rsp_rdata` with a `rsp_valid` pulse after the read latency (see Timing). `req_be` is ignored for reads.
  - Back-to-back operations can be accepted every cycle. Only one operation occurs per cycle, so read-during-write cannot happen.
- **clr:**
  - `clr` high in `RUN` deasserts `req_ready` in the same cycle, so no request is accepted that cycle.
  - On the next edge the state goes to `INIT`, with `cnt=0` and `init_done=0`.
  - Read responses already in flight still complete.
  - `clr` is ignored while in `INIT`. A clear pass is not restarted.
- **Reset mid-INIT:** the clear pass restarts from address 0 after `rst_n` deasserts.

## Timing
- Read latency is 1 cycle by default. A read accepted at edge N has `rsp_valid=1` and data in the cycle following edge N, i.e. data is registered at edge N.
- The `init_done` rise and the first possible `req_ready=1` occur `DEPTH` cycles after `rst_n` deasserts (first rising edge after deassertion = INIT cycle 0).
- `rsp_valid` is a single-cycle pulse per accepted read. Back-to-back reads produce back-to-back pulses in acceptance order.
- Responses are not backpressured: there is no `rsp_ready`, so the consumer must always sink them.

## Configuration
- `RAM_SP_CTRL_OUT_REG_EN`:
  - **Defined:** adds a second output register stage after the array read. Read latency becomes 2 cycles, `rsp_valid` is delayed to match, and throughput remains one read per cycle. Both output stages reset to 0.
  - **Undefined:** read latency is 1 cycle as above.
  - All other behaviour is identical in both builds.

## Test plan
- **Reset and init:** release `rst_n` with `ADDR_W=4`. Expect `req_ready=0` and `init_done=0` for exactly 16 cycles, then both go to 1. Reading addresses 0..15 returns `INIT_VAL` (0).
- **Byte-enable write:** write `0x11223344` to addr 5 with `be=4'b1111`, then write `0xAABBCCDD` to addr 5 with `be=4'b0101`. A read of addr 5 returns `0x11BB33DD` with latency 1 (2 with the macro).
- **Back-to-back reads:** write addr 1..4 with values 1..4, then issue 4 consecutive reads of addr 4,3,2,1. Expect 4 consecutive `rsp_valid` pulses carrying 4,3,2,1.
- **Clear with a read in flight:** read addr 2 (value `0x55`) in cycle N and assert `clr` in cycle N+1.
  - The read response `0x55` still arrives.
  - `req_ready` is 0 in cycle N+1, and a request presented there is not accepted.
  - `init_done` falls, and after `DEPTH` cycles a read of addr 2 returns 0.
- **Reset mid-INIT:** assert `rst_n=0` at INIT cycle 7 of 16. After release, expect a full 16-cycle INIT again and all outputs 0 during reset.
- **Output-register build:** with `RAM_SP_CTRL_OUT_REG_EN` defined, a read accepted at edge N produces `rsp_valid` in the cycle after edge N+1 with the correct data.

Source files
------------

// File: rtl/ram_sp_ctrl.sv
// Single-port synchronous RAM with valid/ready requests, byte enables and a zero-fill clear engine.
// Optional macro RAM_SP_CTRL_OUT_REG_EN adds a second read output register (read latency 2).
module ram_sp_ctrl #(
    parameter int              DATA_W   = 8,
    parameter int              ADDR_W   = 8,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   cnt_reg;
    logic                init_done_reg;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                acc;
    logic                wr_fire;
    logic                rd_fire;
    logic                in_init;
    logic [NB-1:0]       mem_be;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;

    assign in_init   = (state_reg == ST_INIT);
    assign req_ready = (state_reg == ST_RUN) && !clr;
    assign acc       = req_valid && req_ready;
    assign wr_fire   = acc && req_we;
    assign rd_fire   = acc && !req_we;
    assign init_done = init_done_reg;

    // The clear engine owns the single write port for the whole INIT pass.
    assign mem_addr  = in_init ? cnt_reg  : req_addr;
    assign mem_wdata = in_init ? INIT_VAL : req_wdata;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_be
            assign mem_be[gi] = in_init || (wr_fire && req_be[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_be[b]) begin
                mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_INIT;
            cnt_reg       <= '0;
            init_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == {ADDR_W{1'b1}}) begin
                        state_reg     <= ST_RUN;
                        init_done_reg <= 1'b1;
                    end
                end
                default: begin
                    if (clr) begin
                        state_reg     <= ST_INIT;
                        cnt_reg       <= '0;
                        init_done_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

    logic              rd_valid_reg;
    logic [DATA_W-1:0] rd_data_reg;

    // Read data holds its value between reads so rsp_rdata stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            rd_valid_reg <= rd_fire;
            if (rd_fire) begin
                rd_data_reg <= mem[req_addr];
            end
        end
    end

`ifdef RAM_SP_CTRL_OUT_REG_EN
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            out_valid_reg <= rd_valid_reg;
            if (rd_valid_reg) begin
                out_data_reg <= rd_data_reg;
            end
        end
    end

    assign rsp_valid = out_valid_reg;
    assign rsp_rdata = out_data_reg;
`else
    assign rsp_valid = rd_valid_reg;
    assign rsp_rdata = rd_data_reg;
`endif

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Randomized bench for ram_sp_ctrl against an array/queue reference model (DATA_W=32, ADDR_W=4).
module tb_ram_sp_ctrl;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
`ifdef RAM_SP_CTRL_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_be;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              init_done;

    ram_sp_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INIT_VAL('0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    logic [31:0] model_mem [DEPTH];
    rsp_t        rq [$];
    int          init_left;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    endtask

    task automatic model_reset();
        init_left = DEPTH;
        rq.delete();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    // One clock: sample at negedge against the model, then advance the model at posedge.
    task automatic tick();
        logic fire;
        logic exp_ready;
        @(negedge clk);
        exp_ready = (init_left == 0) && !clr;
        check("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
        check("init_done", {31'b0, init_done}, {31'b0, init_left == 0});
        if (rq.size() > 0 && rq[0].due == cyc) begin
            check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("rsp_rdata", rsp_rdata, rq[0].data);
            $display("cyc=%0d read rsp data=%h exp=%h", cyc, rsp_rdata, rq[0].data);
            void'(rq.pop_front());
        end else begin
            check("rsp_idle", {31'b0, rsp_valid}, 32'd0);
        end
        fire = req_valid && exp_ready;
        @(posedge clk);
        cyc++;
        if (init_left > 0) begin
            init_left--;
        end else if (clr) begin
            init_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        end
        if (fire) begin
            if (req_we) begin
                for (int b = 0; b < 4; b++)
                    if (req_be[b]) model_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                $display("cyc=%0d write addr=%0d data=%h be=%b", cyc, req_addr, req_wdata, req_be);
            end else begin
                rq.push_back('{due: cyc + LAT - 1, data: model_mem[req_addr]});
                $display("cyc=%0d read accept addr=%0d", cyc, req_addr);
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_done", {31'b0, init_done}, 32'd0);
        check("rst_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic op(input logic we, input int addr, input logic [31:0] wd, input logic [3:0] be);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = ADDR_W'(addr);
        req_wdata = wd;
        req_be    = be;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        clr = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0;
        rst_n = 1'b1;
        #2;
        apply_reset();

        // Reset mid-INIT: abort at INIT cycle 7, then a full pass again
        idle(7);
        apply_reset();
        idle(DEPTH);
        check("init_done_up", {31'b0, init_done}, 32'd1);

        for (int a = 0; a < DEPTH; a++) op(1'b0, a, '0, '0);
        idle(LAT);

        // Byte-enable merge
        op(1'b1, 5, 32'h11223344, 4'b1111);
        op(1'b1, 5, 32'hAABBCCDD, 4'b0101);
        op(1'b0, 5, '0, '0);
        idle(LAT);
        check("be_merge", rsp_rdata, 32'h11BB33DD);
        op(1'b1, 6, 32'hDEADBEEF, 4'b0000);
        op(1'b0, 6, '0, 4'b1111);
        idle(LAT);
        check("be_zero", rsp_rdata, 32'h0);

        // Back-to-back reads
        for (int a = 1; a <= 4; a++) op(1'b1, a, 32'(a), 4'b1111);
        for (int a = 4; a >= 1; a--) op(1'b0, a, '0, '0);
        idle(LAT + 1);
        check("b2b_last", rsp_rdata, 32'd1);

        // Clear with a read in flight; request during clr must be refused
        op(1'b1, 2, 32'h55, 4'b1111);
        op(1'b0, 2, '0, '0);
        clr = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
        #1 check("clr_ready", {31'b0, req_ready}, 32'd0);
        tick();
        clr = 1'b0; req_valid = 1'b0;
        check("clr_done_low", {31'b0, init_done}, 32'd0);
        idle(DEPTH);
        op(1'b0, 2, '0, '0);
        idle(LAT);
        check("clr_zero", rsp_rdata, 32'd0);

        // Randomized traffic with occasional clears
        for (int i = 0; i < 600; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = $urandom_range(0, 1) == 1;
            req_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
            req_wdata = $urandom;
            req_be    = 4'($urandom_range(0, 15));
            clr       = ($urandom_range(0, 63) == 0);
            tick();
        end
        clr = 1'b0;
        idle(DEPTH + 4);
        check("drain", 32'(rq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
